// File: rtl/sc_player_shiftregister.sv
// Player position register: one-hot position with clear/load/shift commands,
// active-low limit flags, a wrapping move counter and one-cycle status pulses.
module sc_player_shiftregister #(
  parameter int DATAWIDTH  = 8,
  parameter int INIT_BIT   = 3,
  parameter int COUNTWIDTH = 8
) (
  input  logic                  SC_PLAYERREG_CLOCK_50,
  input  logic                  SC_PLAYERREG_RESET_InHigh,
  input  logic                  SC_PLAYERREG_clear_InLow,
  input  logic [1:0]            SC_PLAYERREG_shiftselection_In,
  input  logic [DATAWIDTH-1:0]  SC_PLAYERREG_data_In,
  output logic [DATAWIDTH-1:0]  SC_PLAYERREG_data_Out,
  output logic                  SC_PLAYERREG_leftlimit_OutLow,
  output logic                  SC_PLAYERREG_rightlimit_OutLow,
  output logic [COUNTWIDTH-1:0] SC_PLAYERREG_movecount_Out,
  output logic                  SC_PLAYERREG_moved_Out,
  output logic                  SC_PLAYERREG_error_Out
);

  localparam logic [DATAWIDTH-1:0] INIT_VEC = DATAWIDTH'(1) << INIT_BIT;

  localparam logic [1:0] CMD_LOAD  = 2'b00;
  localparam logic [1:0] CMD_LEFT  = 2'b01;
  localparam logic [1:0] CMD_RIGHT = 2'b10;
  localparam logic [1:0] CMD_HOLD  = 2'b11;

  logic [DATAWIDTH-1:0]  data_q, data_d;
  logic [COUNTWIDTH-1:0] count_q, count_d;
  logic                  moved_q, moved_d;
  logic                  error_q, error_d;
  logic                  load_onehot;

  // A value is one-hot when it is non-zero and clearing its lowest set bit leaves zero.
  assign load_onehot = (SC_PLAYERREG_data_In != '0) &&
                       ((SC_PLAYERREG_data_In & (SC_PLAYERREG_data_In - 1'b1)) == '0);

  always_comb begin
    data_d  = data_q;
    count_d = count_q;
    moved_d = 1'b0;
    error_d = 1'b0;
    if (!SC_PLAYERREG_clear_InLow) begin
      data_d  = INIT_VEC;
      count_d = '0;
    end else begin
      case (SC_PLAYERREG_shiftselection_In)
        CMD_LEFT: begin
          if (!data_q[DATAWIDTH-1]) begin
            data_d  = data_q << 1;
            count_d = count_q + 1'b1;
            moved_d = 1'b1;
          end else begin
            error_d = 1'b1;
          end
        end
        CMD_RIGHT: begin
          if (!data_q[0]) begin
            data_d  = data_q >> 1;
            count_d = count_q + 1'b1;
            moved_d = 1'b1;
          end else begin
            error_d = 1'b1;
          end
        end
        CMD_LOAD: begin
          if (load_onehot) begin
            data_d = SC_PLAYERREG_data_In;
          end else begin
            error_d = 1'b1;
          end
        end
        CMD_HOLD: begin
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge SC_PLAYERREG_CLOCK_50) begin
    if (SC_PLAYERREG_RESET_InHigh) begin
      data_q  <= INIT_VEC;
      count_q <= '0;
      moved_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      count_q <= count_d;
      moved_q <= moved_d;
      error_q <= error_d;
    end
  end

  // Limit flags come straight off the position register so the FSM sees them without delay.
  assign SC_PLAYERREG_data_Out          = data_q;
  assign SC_PLAYERREG_leftlimit_OutLow  = ~data_q[DATAWIDTH-1];
  assign SC_PLAYERREG_rightlimit_OutLow = ~data_q[0];
  assign SC_PLAYERREG_movecount_Out     = count_q;
  assign SC_PLAYERREG_moved_Out         = moved_q;
  assign SC_PLAYERREG_error_Out         = error_q;

endmodule

// File: tb/tb_sc_player_shiftregister.sv
// Bench for sc_player_shiftregister: position-index model checked every cycle,
// plus literal expectations taken from hand-worked command sequences.
module tb_sc_player_shiftregister;

  localparam int W  = 8;
  localparam int IB = 3;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr_n;
  logic [1:0]    sel;
  logic [W-1:0]  din;
  logic [W-1:0]  dout;
  logic          llim_n;
  logic          rlim_n;
  logic [CW-1:0] cnt;
  logic          moved;
  logic          err;

  always #5 clk = ~clk;

  sc_player_shiftregister #(.DATAWIDTH(W), .INIT_BIT(IB), .COUNTWIDTH(CW)) dut (
    .SC_PLAYERREG_CLOCK_50          (clk),
    .SC_PLAYERREG_RESET_InHigh      (rst),
    .SC_PLAYERREG_clear_InLow       (clr_n),
    .SC_PLAYERREG_shiftselection_In (sel),
    .SC_PLAYERREG_data_In           (din),
    .SC_PLAYERREG_data_Out          (dout),
    .SC_PLAYERREG_leftlimit_OutLow  (llim_n),
    .SC_PLAYERREG_rightlimit_OutLow (rlim_n),
    .SC_PLAYERREG_movecount_Out     (cnt),
    .SC_PLAYERREG_moved_Out         (moved),
    .SC_PLAYERREG_error_Out         (err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: the player is a position index and a move tally.
  bit model_valid = 1'b0;
  int m_pos;
  int m_cnt;
  bit m_moved;
  bit m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit c, input logic [1:0] s, input logic [W-1:0] d);
    m_moved = 1'b0;
    m_err   = 1'b0;
    if (r || !c) begin
      m_pos = IB;
      m_cnt = 0;
    end else if (s == 2'b01) begin
      if (m_pos < W - 1) begin
        m_pos++;
        m_cnt   = (m_cnt + 1) % (1 << CW);
        m_moved = 1'b1;
      end else m_err = 1'b1;
    end else if (s == 2'b10) begin
      if (m_pos > 0) begin
        m_pos--;
        m_cnt   = (m_cnt + 1) % (1 << CW);
        m_moved = 1'b1;
      end else m_err = 1'b1;
    end else if (s == 2'b00) begin
      if ($countones(d) == 1) begin
        for (int i = 0; i < W; i++) if (d[i]) m_pos = i;
      end else m_err = 1'b1;
    end
  endtask

  task automatic step(input bit r, input bit c, input logic [1:0] s, input logic [W-1:0] d);
    rst = r; clr_n = c; sel = s; din = d;
    @(posedge clk);
    #1;
    model_step(r, c, s, d);
    model_valid = 1'b1;
    @(negedge clk);
    $display("txn rst=%0b clr_n=%0b sel=%b din=%b -> data=%b cnt=%0d moved=%0b err=%0b",
             r, c, s, d, dout, cnt, moved, err);
  endtask

  always @(negedge clk) begin
    if (model_valid) begin
      logic [W-1:0] exp_data;
      exp_data = W'(1) << m_pos;
      check("data", 32'(dout), 32'(exp_data));
      check("leftlimit", 32'(llim_n), 32'(m_pos != W - 1));
      check("rightlimit", 32'(rlim_n), 32'(m_pos != 0));
      check("movecount", 32'(cnt), 32'(m_cnt));
      check("moved", 32'(moved), 32'(m_moved));
      check("error", 32'(err), 32'(m_err));
    end
  end

  initial begin
    rst = 1'b1; clr_n = 1'b1; sel = 2'b11; din = '0;

    // 1: reset then hold
    step(1, 1, 2'b11, '0);
    step(0, 1, 2'b11, '0);
    check("t1_data", 32'(dout), 32'h08);
    check("t1_cnt", 32'(cnt), 32'd0);
    check("t1_llim", 32'(llim_n), 32'd1);
    check("t1_rlim", 32'(rlim_n), 32'd1);
    check("t1_moved", 32'(moved), 32'd0);
    check("t1_err", 32'(err), 32'd0);

    // 2: walk left into the limit
    step(1, 1, 2'b11, '0);
    step(0, 1, 2'b01, '0);
    check("t2_data1", 32'(dout), 32'h10);
    check("t2_moved1", 32'(moved), 32'd1);
    step(0, 1, 2'b01, '0);
    step(0, 1, 2'b01, '0);
    check("t2_data3", 32'(dout), 32'h40);
    check("t2_llim3", 32'(llim_n), 32'd1);
    step(0, 1, 2'b01, '0);
    check("t2_data4", 32'(dout), 32'h80);
    check("t2_llim4", 32'(llim_n), 32'd0);
    step(0, 1, 2'b01, '0);
    check("t2_data5", 32'(dout), 32'h80);
    check("t2_err5", 32'(err), 32'd1);
    check("t2_moved5", 32'(moved), 32'd0);
    check("t2_cnt5", 32'(cnt), 32'd4);
    step(0, 1, 2'b01, '0);
    check("t2_err6", 32'(err), 32'd1);
    step(0, 1, 2'b11, '0);
    check("t2_err_hold", 32'(err), 32'd0);

    // 3: walk right into the limit
    step(1, 1, 2'b11, '0);
    step(0, 1, 2'b10, '0);
    check("t3_data1", 32'(dout), 32'h04);
    step(0, 1, 2'b10, '0);
    step(0, 1, 2'b10, '0);
    check("t3_data3", 32'(dout), 32'h01);
    check("t3_rlim3", 32'(rlim_n), 32'd0);
    step(0, 1, 2'b10, '0);
    check("t3_data4", 32'(dout), 32'h01);
    check("t3_err4", 32'(err), 32'd1);
    check("t3_cnt4", 32'(cnt), 32'd3);

    // 4: parallel loads, valid and invalid
    step(1, 1, 2'b11, '0);
    step(0, 1, 2'b01, '0);
    step(0, 1, 2'b00, 8'b0100_0000);
    check("t4_data_ok", 32'(dout), 32'h40);
    check("t4_cnt_ok", 32'(cnt), 32'd1);
    check("t4_moved_ok", 32'(moved), 32'd0);
    check("t4_err_ok", 32'(err), 32'd0);
    step(0, 1, 2'b00, 8'b0110_0000);
    check("t4_data_multi", 32'(dout), 32'h40);
    check("t4_err_multi", 32'(err), 32'd1);
    step(0, 1, 2'b00, 8'b0000_0000);
    check("t4_data_zero", 32'(dout), 32'h40);
    check("t4_err_zero", 32'(err), 32'd1);
    step(0, 1, 2'b00, 8'b0000_0001);
    check("t4_data_bit0", 32'(dout), 32'h01);

    // 5: clear overrides a shift; reset with clear gives the same result
    step(1, 1, 2'b11, '0);
    for (int i = 0; i < 7; i++) step(0, 1, (i % 2 == 0) ? 2'b01 : 2'b10, '0);
    check("t5_cnt7", 32'(cnt), 32'd7);
    step(0, 0, 2'b01, '0);
    check("t5_clr_data", 32'(dout), 32'h08);
    check("t5_clr_cnt", 32'(cnt), 32'd0);
    check("t5_clr_moved", 32'(moved), 32'd0);
    step(0, 1, 2'b01, '0);
    step(0, 1, 2'b01, '0);
    step(1, 0, 2'b01, '0);
    check("t5_rst_data", 32'(dout), 32'h08);
    check("t5_rst_cnt", 32'(cnt), 32'd0);
    check("t5_rst_moved", 32'(moved), 32'd0);
    check("t5_rst_err", 32'(err), 32'd0);

    // 6: counter wraps after 256 accepted shifts
    step(1, 1, 2'b11, '0);
    for (int i = 0; i < 255; i++) step(0, 1, (i % 2 == 0) ? 2'b01 : 2'b10, '0);
    check("t6_cnt255", 32'(cnt), 32'd255);
    check("t6_data255", 32'(dout), 32'h10);
    step(0, 1, 2'b01, '0);
    check("t6_cnt_wrap", 32'(cnt), 32'd0);
    check("t6_moved_wrap", 32'(moved), 32'd1);
    check("t6_data_wrap", 32'(dout), 32'h20);
    step(0, 1, 2'b11, '0);

    model_valid = 1'b0;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
